// File: rtl/sccb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sccb_arbiter_pkg
// Shared definitions for the SCCB transfer arbiter: FSM state encoding,
// the default SCCB device write address, the sensor soft-reset register
// address and the width of the shared timeout/gap down-counter.
// -----------------------------------------------------------------------------
package sccb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Default SCCB device write address prefixed to every transfer.
    localparam logic [7:0]  SCCB_DEV_ADDR = 8'h78;

    // Writing a value with bit 7 set to this register soft-resets the sensor,
    // which then needs a much longer quiet period before the next access.
    localparam logic [15:0] SOFT_RST_REG  = 16'h3008;

    // One counter serves both the ISSUE timeout and the GAP length; 21 bits
    // cover the largest default count (2,000,000 cycles).
    localparam int CNT_W = 21;

endpackage

// File: rtl/sccb_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_arbiter
// Two-requester round-robin arbiter in front of an SCCB (I2C-like) master.
// A granted requester's payload is latched with the device address and
// presented to the master while i2c_start is high; the transfer completes on
// a rising edge of tr_end or aborts after TIMEOUT_CYC cycles. Every transfer
// is followed by an idle gap (longer after a sensor soft-reset write).
//
// Ports
//   clk_25M    in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req[1:0]   in   transfer request; [0] init sequencer, [1] runtime writer
//   wdata0/1   in   {reg_addr[15:0], reg_val[7:0]} per requester
//   done[1:0]  out  one-cycle completion pulse for the served requester
//   err[1:0]   out  one-cycle timeout flag, coincident with done
//   i2c_start  out  start level to the SCCB master (high during ISSUE)
//   i2c_data   out  {DEV_ADDR, latched payload}, changes only on a grant
//   tr_end     in   transfer-end level from the SCCB master (clk_25M domain)
//   busy       out  high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module sccb_arbiter
    import sccb_arbiter_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR     = SCCB_DEV_ADDR,
    parameter int unsigned GAP_CYC      = 5000,     // must be >= 1
    parameter int unsigned RST_WAIT_CYC = 125000,   // must be >= 1
    parameter int unsigned TIMEOUT_CYC  = 2000000   // must be >= 1
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [23:0] wdata0,
    input  logic [23:0] wdata1,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        i2c_start,
    output logic [31:0] i2c_data,
    input  logic        tr_end,
    output logic        busy
);

    // Counter load values: a load of N-1 followed by counting down to zero
    // spans exactly N cycles in the state that loaded it.
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD      = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LOAD = CNT_W'(RST_WAIT_CYC - 1);

    // Round-robin pick: on a tie the requester that was not served last wins;
    // otherwise the only active requester wins.
    function automatic logic pick_grant(input logic [1:0] r, input logic last);
        if (r == 2'b11)
            return ~last;
        else
            return r[1];
    endfunction

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       data_q, data_nxt;
    logic              last_grant, last_nxt;   // also the requester being served
    logic [1:0]        done_q, done_nxt;
    logic [1:0]        err_q, err_nxt;
    logic              tr_q;
    logic              tr_rise;
    logic              grant_sel;
    logic              soft_rst_write;
    logic [CNT_W-1:0]  gap_load;

    // Only a fresh rising edge counts, so a tr_end still high from a previous
    // transfer when ISSUE is entered cannot complete the new one.
    assign tr_rise = tr_end & ~tr_q;

    assign soft_rst_write = (data_q[23:8] == SOFT_RST_REG) && data_q[7];
    assign gap_load       = soft_rst_write ? RST_WAIT_LOAD : GAP_LOAD;

    // NOTE: every variable assigned below gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        last_nxt  = last_grant;
        done_nxt  = 2'b00;
        err_nxt   = 2'b00;
        grant_sel = 1'b0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_sel = pick_grant(req, last_grant);
                    last_nxt  = grant_sel;
                    data_nxt  = {DEV_ADDR, (grant_sel ? wdata1 : wdata0)};
                    cnt_nxt   = TIMEOUT_LOAD;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                if (tr_rise) begin
                    done_nxt[last_grant] = 1'b1;
                    cnt_nxt              = gap_load;
                    state_nxt            = GAP;
                end else if (cnt == '0) begin
                    done_nxt[last_grant] = 1'b1;
                    err_nxt[last_grant]  = 1'b1;
                    cnt_nxt              = gap_load;
                    state_nxt            = GAP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            GAP: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            data_q     <= '0;
            last_grant <= 1'b1;     // port 0 wins the first tie after reset
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            tr_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_q     <= data_nxt;
            last_grant <= last_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
            tr_q       <= tr_end;
        end
    end

    assign i2c_start = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign i2c_data  = data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccb_arbiter
// Directed self-checking bench for sccb_arbiter. Gap, soft-reset wait and
// timeout are scaled down so the run stays short; every expected latency is
// derived from those parameters.
// -----------------------------------------------------------------------------
module tb_sccb_arbiter;
    import sccb_arbiter_pkg::*;

    localparam int GAP  = 20;
    localparam int RSTW = 120;
    localparam int TMO  = 200;

    logic        clk_25M = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [23:0] wdata0, wdata1;
    logic [1:0]  done, err;
    logic        i2c_start;
    logic [31:0] i2c_data;
    logic        tr_end;
    logic        busy;

    int n_checks    = 0;
    int n_pass      = 0;
    int done_pulses = 0;

    sccb_arbiter #(
        .DEV_ADDR     (8'h78),
        .GAP_CYC      (GAP),
        .RST_WAIT_CYC (RSTW),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk_25M   (clk_25M),
        .rst       (rst),
        .req       (req),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done      (done),
        .err       (err),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .tr_end    (tr_end),
        .busy      (busy)
    );

    always #20 clk_25M = ~clk_25M;

    always @(negedge clk_25M)
        if (done != 2'b00) done_pulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk_25M);
    endtask

    // Waits (bounded) for i2c_start; returns the number of negedges waited.
    task automatic wait_start(input string tag, input int max_cyc, output int w);
        w = 0;
        while (!i2c_start && w < max_cyc) begin
            tick();
            w++;
        end
        check({tag, "_start"}, {31'd0, i2c_start}, 32'd1);
    endtask

    // Called on an ISSUE negedge: waits lat cycles, pulses tr_end, checks done.
    task automatic finish_xfer(input string tag, input int port, input int lat);
        logic [1:0] exp_d;
        exp_d = (port == 1) ? 2'b10 : 2'b01;
        repeat (lat) tick();
        tr_end = 1'b1;
        tick();
        check({tag, "_done"},  {30'd0, done}, {30'd0, exp_d});
        check({tag, "_err"},   {30'd0, err},  32'd0);
        check({tag, "_stop"},  {31'd0, i2c_start}, 32'd0);
        tr_end = 1'b0;
    endtask

    // Called on the done negedge: counts busy negedges (including this one).
    task automatic measure_gap(input string tag, input int exp);
        int n;
        n = 1;
        tick();
        check({tag, "_done_clr"}, {30'd0, done, err}, 32'd0);
        while (busy && n < 5000) begin
            n++;
            tick();
        end
        check({tag, "_gap"}, n, exp);
    endtask

    initial begin
        int w;
        int n;
        int p;

        rst    = 1'b1;
        req    = 2'b00;
        tr_end = 1'b0;
        wdata0 = '0;
        wdata1 = '0;
        repeat (3) tick();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, i2c_start}, 32'd0);
        check("rst_done",  {30'd0, done}, 32'd0);
        check("rst_err",   {30'd0, err}, 32'd0);
        check("rst_data",  i2c_data, 32'd0);
        rst = 1'b0;
        tick();

        // Single request, normal gap; later wdata changes must be ignored.
        wdata0 = 24'h300842;
        req    = 2'b01;
        wait_start("t030", 20, w);
        check("t030_lat",  w, 32'd1);
        check("t030_data", i2c_data, 32'h78300842);
        check("t030_busy", {31'd0, busy}, 32'd1);
        wdata0 = 24'hABCDEF;
        finish_xfer("t030", 0, 100);
        req = 2'b00;
        measure_gap("t030", GAP);
        check("t030_hold", i2c_data, 32'h78300842);

        // Stale tr_end: high on ISSUE entry must not complete.
        tr_end = 1'b1;
        wdata0 = 24'h123456;
        req    = 2'b01;
        wait_start("t034", 20, w);
        repeat (5) tick();
        check("t034_stale_done",  {30'd0, done}, 32'd0);
        check("t034_stale_start", {31'd0, i2c_start}, 32'd1);
        tr_end = 1'b0;
        repeat (3) tick();
        finish_xfer("t034", 0, 0);
        req = 2'b00;
        measure_gap("t034", GAP);

        // Timeout: tr_end never rises.
        wdata0 = 24'h1000AA;
        req    = 2'b01;
        wait_start("t033", 20, w);
        n = 0;
        while (i2c_start && n < 1000) begin
            n++;
            tick();
        end
        check("t033_issue_len", n, TMO);
        check("t033_done", {30'd0, done}, 32'd1);
        check("t033_err",  {30'd0, err},  32'd1);
        req = 2'b00;
        measure_gap("t033", GAP);

        // Soft-reset write: long wait before the next grant.
        wdata0 = 24'h300882;
        req    = 2'b01;
        wait_start("t032", 20, w);
        finish_xfer("t032", 0, 10);
        n = 0;
        while (!i2c_start && n < 1000) begin
            n++;
            tick();
        end
        check("t032_next_grant", n, RSTW + 1);
        finish_xfer("t032b", 0, 4);
        req = 2'b00;
        measure_gap("t032b", RSTW);

        // Reset in the middle of ISSUE.
        wdata0 = 24'h200011;
        req    = 2'b01;
        wait_start("t035", 20, w);
        repeat (50) tick();
        check("t035_pre_start", {31'd0, i2c_start}, 32'd1);
        p = done_pulses;
        #5 rst = 1'b1;
        #1;
        check("t035_start", {31'd0, i2c_start}, 32'd0);
        check("t035_busy",  {31'd0, busy}, 32'd0);
        check("t035_data",  i2c_data, 32'd0);
        check("t035_done",  {30'd0, done, err}, 32'd0);
        req = 2'b00;
        repeat (4) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t035_nodone", done_pulses, p);

        // Round robin after reset: both held -> 0, 1, 0.
        wdata0 = 24'h0A0B01;
        wdata1 = 24'h0C0D02;
        req    = 2'b11;
        wait_start("rr0", 20, w);
        check("rr0_data", i2c_data, 32'h780A0B01);
        finish_xfer("rr0", 0, 7);
        wait_start("rr1", GAP + 10, w);
        check("rr1_wait", w, GAP + 1);
        check("rr1_data", i2c_data, 32'h780C0D02);
        finish_xfer("rr1", 1, 7);
        wait_start("rr2", GAP + 10, w);
        check("rr2_data", i2c_data, 32'h780A0B01);
        finish_xfer("rr2", 0, 7);
        req = 2'b00;
        measure_gap("rr2", GAP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h78, meaning the SCCB device write address prefixed to every transfer.
REQ-002 SHALL have parameter GAP_CYC, default 5000, meaning the idle clk_25M cycles after each transfer.
REQ-003 SHALL have parameter RST_WAIT_CYC, default 125000, meaning the gap after a software-reset write (5 ms).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000000, meaning the maximum cycles in ISSUE before abort.
REQ-005 SHALL have port clk_25M, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port req, input, 2 bits: per-requester transfer request; [0] is the init sequencer, [1] is the runtime writer.
REQ-008 SHALL have ports wdata0 and wdata1, input, 24 bits each: {reg_addr[15:0], reg_val[7:0]} per requester.
REQ-009 SHALL have port done, output, 2 bits: one-cycle completion pulse per requester.
REQ-010 SHALL have port err, output, 2 bits: one-cycle timeout flag, coincident with done.
REQ-011 SHALL have port i2c_start, output, 1 bit: start level to the SCCB master.
REQ-012 SHALL have port i2c_data, output, 32 bits: {DEV_ADDR, latched payload}.
REQ-013 SHALL have port tr_end, input, 1 bit: transfer-end level from the SCCB master, synchronous to clk_25M.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, GAP.
REQ-016 In IDLE, when req is non-zero, the block SHALL grant one requester and latch its wdata into i2c_data[23:0], then enter ISSUE on the next edge.
REQ-017 Arbitration SHALL be round-robin via a last-grant bit; on simultaneous requests the requester other than last-grant SHALL win; last-grant SHALL reset to 1, so port 0 wins first.
REQ-018 In ISSUE, i2c_start SHALL be 1; completion SHALL be a tr_end rising edge (tr_end=1 with the registered tr_end=0); a tr_end already high on ISSUE entry SHALL NOT complete.
REQ-019 On completion the block SHALL deassert i2c_start, pulse done[g] for one cycle, and enter GAP.
REQ-020 When the ISSUE cycle count reaches TIMEOUT_CYC, the block SHALL drop i2c_start, pulse done[g] and err[g] together, and enter GAP.
REQ-021 GAP SHALL last GAP_CYC cycles, or RST_WAIT_CYC if the latched payload has reg_addr=16'h3008 and reg_val[7]=1; the block SHALL then return to IDLE.
REQ-022 Requesters SHALL hold req and wdata until done, then drop req within GAP; a request still high on IDLE re-entry SHALL be treated as a new transfer.
REQ-023 A single 21-bit down-counter SHALL serve both timeout and gap.
REQ-024 i2c_data SHALL change only on a grant; it SHALL stay stable through ISSUE and GAP.
REQ-025 Changes to wdata after the grant SHALL be ignored.

Reset
REQ-026 Asserting rst at any time, including mid-ISSUE, SHALL force IDLE with i2c_start=0, done=0, err=0, busy=0, i2c_data=0, counter=0, last-grant=1 and registered tr_end=0.
REQ-027 After rst deasserts, the first grant SHALL occur no earlier than the first clk_25M edge.

Structure
REQ-028 A shared package SHALL hold the state enum, the SCCB_DEV_ADDR constant (8'h78) and the soft-reset register constant (16'h3008).
REQ-029 No sub-modules are required; the arbiter pick SHALL be a local function.

Verification
REQ-030 Single request: req=01, wdata0=24'h300842, tr_end pulse 100 cycles after i2c_start -> i2c_data=32'h78300842, done=01 for one cycle, busy low after 5000 gap cycles.
REQ-031 Simultaneous requests after reset: req=11 -> port 0 served first, then port 1; grant order 0,1,0 while both stay asserted.
REQ-032 Soft reset: wdata0=24'h300882 completes -> next grant no earlier than 125000 cycles after done.
REQ-033 Timeout: tr_end held 0 -> after 2000000 cycles, i2c_start=0 and done[0]=err[0]=1 for the same single cycle.
REQ-034 Stale tr_end: tr_end=1 on ISSUE entry, then 0, then 1 -> completion only on the second rise.
REQ-035 Reset mid-ISSUE: assert rst 50 cycles into ISSUE -> i2c_start=0 and busy=0 immediately, with no done pulse.
